// File: rtl/r2_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// r2_butterfly_pipe
//   Four-stage pipelined fixed-point radix-2 DIT butterfly:
//     F0 = x1 + x2*W,  F1 = x1 - x2*W
//   W = cos - j*sin (forward) or cos + j*sin (inverse), selected per vector.
//   Optional divide-by-2 per vector, saturating outputs, sticky sat flag.
//   One butterfly per clock; a single global enable stalls the whole pipe
//   when the output is valid and not accepted downstream.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   input accepted when in_valid & in_ready (combinational)
//   r1, i1     x1 real/imag          (signed DATA_W)
//   r2, i2     x2 real/imag          (signed DATA_W)
//   tw_cos     twiddle cosine        (signed Q1.(TW_W-1))
//   tw_sin     twiddle sine          (signed Q1.(TW_W-1))
//   in_inv     0: forward twiddle, 1: inverse twiddle
//   in_scale   1: halve both results
//   out_valid  result valid
//   out_ready  downstream accepts when out_valid & out_ready
//   f0r, f0i   F0 real/imag          (signed DATA_W, saturated)
//   f1r, f1i   F1 real/imag          (signed DATA_W, saturated)
//   clr_sat    synchronous clear of sat_flag (set wins)
//   sat_flag   sticky saturation indicator
//   busy       OR of all stage valid bits (combinational)
// ---------------------------------------------------------------------------
module r2_butterfly_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] r1,
  input  logic signed [DATA_W-1:0] i1,
  input  logic signed [DATA_W-1:0] r2,
  input  logic signed [DATA_W-1:0] i2,
  input  logic signed [TW_W-1:0]   tw_cos,
  input  logic signed [TW_W-1:0]   tw_sin,
  input  logic                     in_inv,
  input  logic                     in_scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] f0r,
  output logic signed [DATA_W-1:0] f0i,
  output logic signed [DATA_W-1:0] f1r,
  output logic signed [DATA_W-1:0] f1i,
  input  logic                     clr_sat,
  output logic                     sat_flag,
  output logic                     busy
);

  // Width plan: products fit DATA_W+TW_W (the only 2^(N-1)*2^(M-1) case is
  // positive and still representable); the cross sum needs one extra bit;
  // after the Q1.(TW_W-1) shift the twiddled value needs DATA_W+2 bits and
  // x1 +/- t needs DATA_W+3 bits.
  localparam int unsigned SW_W   = TW_W + 1;
  localparam int unsigned PROD_W = DATA_W + TW_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned T_W    = DATA_W + 2;
  localparam int unsigned F_W    = DATA_W + 3;
  localparam int unsigned SH     = TW_W - 1;

  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1) <<< (TW_W - 2);
  localparam logic signed [F_W-1:0]   SAT_MAX = F_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [F_W-1:0]   SAT_MIN = ~SAT_MAX;

  // Optional halving with round half up.
  function automatic logic signed [F_W-1:0] half_rnd(input logic signed [F_W-1:0] v,
                                                     input logic                  sc);
    half_rnd = sc ? ((v + F_W'(1)) >>> 1) : v;
  endfunction

  function automatic logic is_sat(input logic signed [F_W-1:0] v);
    is_sat = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [F_W-1:0] v);
    if (v > SAT_MAX)      clamp = DATA_W'(SAT_MAX);
    else if (v < SAT_MIN) clamp = DATA_W'(SAT_MIN);
    else                  clamp = DATA_W'(v);
  endfunction

  // Global pipeline enable
  logic en;

  // S1: registered inputs with effective sine
  logic                     s1_v_q;
  logic signed [DATA_W-1:0] s1_r1_q, s1_i1_q, s1_r2_q, s1_i2_q;
  logic signed [TW_W-1:0]   s1_c_q;
  logic signed [SW_W-1:0]   s1_s_q, s1_s_d;
  logic                     s1_scale_q;

  // S2: partial products
  logic                     s2_v_q;
  logic signed [DATA_W-1:0] s2_r1_q, s2_i1_q;
  logic                     s2_scale_q;
  logic signed [PROD_W-1:0] s2_prc_q, s2_pis_q, s2_pic_q, s2_prs_q;
  logic signed [PROD_W-1:0] s2_prc_d, s2_pis_d, s2_pic_d, s2_prs_d;

  // S3: rounded twiddled x2
  logic                     s3_v_q;
  logic signed [DATA_W-1:0] s3_r1_q, s3_i1_q;
  logic                     s3_scale_q;
  logic signed [T_W-1:0]    s3_tr_q, s3_ti_q, s3_tr_d, s3_ti_d;
  logic signed [SUM_W-1:0]  sum_r, sum_i;

  // S4: output registers
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] f0r_q, f0i_q, f1r_q, f1i_q;
  logic signed [DATA_W-1:0] f0r_d, f0i_d, f1r_d, f1i_d;
  logic                     sat_q;
  logic signed [F_W-1:0]    a0r, a0i, a1r, a1i;
  logic                     sat_any;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;
  assign busy     = s1_v_q | s2_v_q | s3_v_q | out_valid_q;

  assign out_valid = out_valid_q;
  assign f0r       = f0r_q;
  assign f0i       = f0i_q;
  assign f1r       = f1r_q;
  assign f1i       = f1i_q;
  assign sat_flag  = sat_q;

  // Effective sine: widened by one bit so negating the most negative value is exact.
  always_comb begin
    s1_s_d = SW_W'(tw_sin);
    if (in_inv) s1_s_d = -SW_W'(tw_sin);
  end

  // Products: operands sign-extended to the product width first.
  always_comb begin
    s2_prc_d = PROD_W'(s1_r2_q) * PROD_W'(s1_c_q);
    s2_pis_d = PROD_W'(s1_i2_q) * PROD_W'(s1_s_q);
    s2_pic_d = PROD_W'(s1_i2_q) * PROD_W'(s1_c_q);
    s2_prs_d = PROD_W'(s1_r2_q) * PROD_W'(s1_s_q);
  end

  // Cross sums, round half up, drop the Q fraction bits.
  always_comb begin
    sum_r   = SUM_W'(s2_prc_q) + SUM_W'(s2_pis_q) + RND;
    sum_i   = SUM_W'(s2_pic_q) - SUM_W'(s2_prs_q) + RND;
    s3_tr_d = T_W'(sum_r >>> SH);
    s3_ti_d = T_W'(sum_i >>> SH);
  end

  // Butterfly add/sub, optional halving, saturation.
  always_comb begin
    a0r = half_rnd(F_W'(s3_r1_q) + F_W'(s3_tr_q), s3_scale_q);
    a0i = half_rnd(F_W'(s3_i1_q) + F_W'(s3_ti_q), s3_scale_q);
    a1r = half_rnd(F_W'(s3_r1_q) - F_W'(s3_tr_q), s3_scale_q);
    a1i = half_rnd(F_W'(s3_i1_q) - F_W'(s3_ti_q), s3_scale_q);
    f0r_d   = clamp(a0r);
    f0i_d   = clamp(a0i);
    f1r_d   = clamp(a1r);
    f1i_d   = clamp(a1i);
    sat_any = is_sat(a0r) | is_sat(a0i) | is_sat(a1r) | is_sat(a1i);
  end

  // Pipeline registers: all stages advance together on en; data only loads
  // behind a valid so bubbles do not disturb held values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q      <= 1'b0;
      s1_r1_q     <= '0;
      s1_i1_q     <= '0;
      s1_r2_q     <= '0;
      s1_i2_q     <= '0;
      s1_c_q      <= '0;
      s1_s_q      <= '0;
      s1_scale_q  <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_r1_q     <= '0;
      s2_i1_q     <= '0;
      s2_scale_q  <= 1'b0;
      s2_prc_q    <= '0;
      s2_pis_q    <= '0;
      s2_pic_q    <= '0;
      s2_prs_q    <= '0;
      s3_v_q      <= 1'b0;
      s3_r1_q     <= '0;
      s3_i1_q     <= '0;
      s3_scale_q  <= 1'b0;
      s3_tr_q     <= '0;
      s3_ti_q     <= '0;
      out_valid_q <= 1'b0;
      f0r_q       <= '0;
      f0i_q       <= '0;
      f1r_q       <= '0;
      f1i_q       <= '0;
    end else if (en) begin
      s1_v_q      <= in_valid;
      s2_v_q      <= s1_v_q;
      s3_v_q      <= s2_v_q;
      out_valid_q <= s3_v_q;
      if (in_valid) begin
        s1_r1_q    <= r1;
        s1_i1_q    <= i1;
        s1_r2_q    <= r2;
        s1_i2_q    <= i2;
        s1_c_q     <= tw_cos;
        s1_s_q     <= s1_s_d;
        s1_scale_q <= in_scale;
      end
      if (s1_v_q) begin
        s2_r1_q    <= s1_r1_q;
        s2_i1_q    <= s1_i1_q;
        s2_scale_q <= s1_scale_q;
        s2_prc_q   <= s2_prc_d;
        s2_pis_q   <= s2_pis_d;
        s2_pic_q   <= s2_pic_d;
        s2_prs_q   <= s2_prs_d;
      end
      if (s2_v_q) begin
        s3_r1_q    <= s2_r1_q;
        s3_i1_q    <= s2_i1_q;
        s3_scale_q <= s2_scale_q;
        s3_tr_q    <= s3_tr_d;
        s3_ti_q    <= s3_ti_d;
      end
      if (s3_v_q) begin
        f0r_q <= f0r_d;
        f0i_q <= f0i_d;
        f1r_q <= f1r_d;
        f1i_q <= f1i_d;
      end
    end
  end

  // Sticky saturation flag: setting on an S4 load wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (en && s3_v_q && sat_any) begin
      sat_q <= 1'b1;
    end else if (clr_sat) begin
      sat_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_r2_butterfly_pipe
//   Table of hand-computed vectors plus hand-written sequences for latency,
//   sticky/priority saturation flag, backpressure and mid-flight reset.
//   Expected results are queued on acceptance and compared on output.
// ---------------------------------------------------------------------------
module tb_r2_butterfly_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid, in_ready, in_inv, in_scale;
  logic signed [15:0] r1, i1, r2, i2, tw_cos, tw_sin;
  logic               out_valid, out_ready;
  logic signed [15:0] f0r, f0i, f1r, f1i;
  logic               clr_sat, sat_flag, busy;

  always #5 clk = ~clk;

  r2_butterfly_pipe #(.DATA_W(16), .TW_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .i1(i1), .r2(r2), .i2(i2),
    .tw_cos(tw_cos), .tw_sin(tw_sin),
    .in_inv(in_inv), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .f0r(f0r), .f0i(f0i), .f1r(f1r), .f1i(f1i),
    .clr_sat(clr_sat), .sat_flag(sat_flag), .busy(busy)
  );

  typedef struct {
    logic signed [15:0] r1, i1, r2, i2, c, s;
    logic               inv, scale;
  } vin_t;

  typedef struct {
    logic signed [15:0] f0r, f0i, f1r, f1i;
    logic               sat;
  } vout_t;

  typedef struct {
    vin_t  in;
    vout_t exp;
  } rec_t;

  int    checks = 0;
  int    errors = 0;
  vout_t sb[$];
  rec_t  tbl[9];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk(input int a, input int b, input int c, input int d,
                              input int co, input int si, input bit inv, input bit sc,
                              input int e0, input int e1, input int e2, input int e3,
                              input bit es);
    rec_t t;
    t.in.r1 = 16'(a);  t.in.i1 = 16'(b);  t.in.r2 = 16'(c);  t.in.i2 = 16'(d);
    t.in.c  = 16'(co); t.in.s  = 16'(si); t.in.inv = inv;    t.in.scale = sc;
    t.exp.f0r = 16'(e0); t.exp.f0i = 16'(e1); t.exp.f1r = 16'(e2); t.exp.f1i = 16'(e3);
    t.exp.sat = es;
    return t;
  endfunction

  // Reference arithmetic in wide integers.
  function automatic vout_t model(input vin_t v);
    longint s, tr, ti;
    longint a[4];
    vout_t  o;
    s  = v.inv ? -longint'(v.s) : longint'(v.s);
    tr = longint'(v.r2) * longint'(v.c) + longint'(v.i2) * s;
    ti = longint'(v.i2) * longint'(v.c) - longint'(v.r2) * s;
    tr = (tr + 64'sd16384) >>> 15;
    ti = (ti + 64'sd16384) >>> 15;
    a[0] = longint'(v.r1) + tr;
    a[1] = longint'(v.i1) + ti;
    a[2] = longint'(v.r1) - tr;
    a[3] = longint'(v.i1) - ti;
    o.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v.scale) a[k] = (a[k] + 64'sd1) >>> 1;
      if (a[k] > 64'sd32767)       begin a[k] = 64'sd32767;  o.sat = 1'b1; end
      else if (a[k] < -64'sd32768) begin a[k] = -64'sd32768; o.sat = 1'b1; end
    end
    o.f0r = 16'(a[0]); o.f0i = 16'(a[1]); o.f1r = 16'(a[2]); o.f1i = 16'(a[3]);
    return o;
  endfunction

  // Output monitor: compare every delivered result against the queue head.
  always @(negedge clk) begin : monitor
    vout_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got f0=(%0d,%0d) with no pending vector", f0r, f0i);
      end else begin
        e = sb.pop_front();
        check("f0r", f0r, e.f0r);
        check("f0i", f0i, e.f0i);
        check("f1r", f1r, e.f1r);
        check("f1i", f1i, e.f1i);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after acceptance, in_valid left high.
  task automatic send(input vin_t v, input vout_t e);
    int n;
    n = 0;
    r1 = v.r1; i1 = v.i1; r2 = v.r2; i2 = v.i2;
    tw_cos = v.c; tw_sin = v.s; in_inv = v.inv; in_scale = v.scale;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0d required 1", in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    check("busy_idle", busy, 0);
  endtask

  task automatic pulse_clr();
    clr_sat = 1'b1;
    @(posedge clk);
    #1;
    clr_sat = 1'b0;
    @(negedge clk);
    check("sat_cleared", sat_flag, 0);
    @(posedge clk);
    #1;
  endtask

  // out_valid must be low 3 cycles and high on the 4th after the accept cycle.
  task automatic latency_test(input rec_t t);
    logic v3, v4;
    v3 = 1'b0;
    v4 = 1'b0;
    send(t.in, t.exp);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) v3 = out_valid;
      if (k == 4) v4 = out_valid;
    end
    check("latency_cycle3", v3, 0);
    check("latency_cycle4", v4, 1);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vin_t  v;
    vout_t held;

    tbl[0] = mk(100, 50, 20, -10, 32767, 0,     0, 0, 120, 40, 80, 60, 0);
    tbl[1] = mk(100, 50, 20, -10, 32767, 0,     0, 1, 60, 20, 40, 30, 0);
    tbl[2] = mk(100, 50, 20, -10, 0,     32767, 0, 0, 90, 30, 110, 70, 0);
    tbl[3] = mk(100, 50, 20, -10, 0,     32767, 1, 0, 110, 70, 90, 30, 0);
    tbl[4] = mk(32767, 0, 32767, 0, 32767, 0,   0, 0, 32767, 0, 1, 0, 1);
    tbl[5] = mk(-32768, 0, 32767, 0, 32767, 0,  0, 0, -2, 0, -32768, 0, 1);
    tbl[6] = mk(100, 50, 20, -10, 0,     32767, 1, 1, 55, 35, 45, 15, 0);
    tbl[7] = mk(-101, -3, 0, 0, 32767, 0,       0, 1, -50, -1, -50, -1, 0);
    tbl[8] = mk(0, 0, -32768, -32768, -32768, -32768, 1, 1, 0, 32767, 0, -32768, 1);

    in_valid = 1'b0; in_inv = 1'b0; in_scale = 1'b0;
    r1 = '0; i1 = '0; r2 = '0; i2 = '0; tw_cos = '0; tw_sin = '0;
    out_ready = 1'b1;
    clr_sat = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_f0r", f0r, 0);
    check("rst_f1i", f1i, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Identity vector with latency measurement
    latency_test(tbl[0]);

    // Table: one vector at a time, then saturation flag state
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].in, tbl[i].exp);
      in_valid = 1'b0;
      drain();
      check($sformatf("sat_after_vec%0d", i), sat_flag, tbl[i].exp.sat);
      if (sat_flag) pulse_clr();
    end

    // Sticky: a clean vector after a saturated one keeps the flag
    send(tbl[4].in, tbl[4].exp);
    send(tbl[0].in, tbl[0].exp);
    in_valid = 1'b0;
    drain();
    check("sat_sticky", sat_flag, 1);
    pulse_clr();

    // Set beats clear when both land on the same cycle
    send(tbl[4].in, tbl[4].exp);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr_sat = 1'b1;
    @(posedge clk);
    #1;
    clr_sat = 1'b0;
    @(negedge clk);
    check("sat_set_priority", sat_flag, 1);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: 8 back-to-back vectors, out_ready low 3 cycles after first output
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          v.r1 = 16'(1000 * k - 3500);
          v.i1 = 16'(2000 - 700 * k);
          v.r2 = 16'(3000 * k - 9000);
          v.i2 = 16'(2500 - 1500 * k);
          v.c  = 16'(23170 - 4000 * k);
          v.s  = 16'(8000 * k - 28000);
          v.inv   = k[0];
          v.scale = k[1];
          send(v, model(v));
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          n++;
          @(negedge clk);
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL bp_first_output: out_valid %0d required 1", out_valid);
        end else begin
          @(posedge clk);
          #1;
          out_ready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            if (k == 0) begin
              held.f0r = f0r; held.f0i = f0i; held.f1r = f1r; held.f1i = f1i;
            end else begin
              check("bp_hold_f0r", f0r, held.f0r);
              check("bp_hold_f0i", f0i, held.f0i);
              check("bp_hold_f1r", f1r, held.f1r);
              check("bp_hold_f1i", f1i, held.f1i);
            end
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      end
    join
    drain();

    // Reset with three vectors in flight; sat_flag still set from the priority case
    for (int k = 0; k < 3; k++) send(tbl[k].in, tbl[k].exp);
    in_valid = 1'b0;
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_sat", sat_flag, 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sat", sat_flag, 0);
    check("mid_rst_f0r", f0r, 0);
    check("mid_rst_f0i", f0i, 0);
    check("mid_rst_f1r", f1r, 0);
    check("mid_rst_f1i", f1i, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    latency_test(tbl[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
